// File: rtl/stream_pkg.sv
// Shared stream types: source identifiers and the round-robin reset pointer.
package stream_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // Pointer starts at B so that A wins the first contention after reset.
  localparam src_t RST_LAST_SRC = SRC_B;

  function automatic src_t other_src(input src_t s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux.sv
// Single-bit 2:1 multiplexer used for data steering.
module mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rr_grant2.sv
// Two-way round-robin grant decision; purely combinational.
module rr_grant2
  import stream_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  src_t last,
  output logic grant_a,
  output logic grant_b,
  output src_t sel
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    sel     = SRC_A;
    case ({req_a, req_b})
      2'b10: begin
        grant_a = 1'b1;
        sel     = SRC_A;
      end
      2'b01: begin
        grant_b = 1'b1;
        sel     = SRC_B;
      end
      2'b11: begin
        // Contention: favour whichever source did not win last time.
        sel     = other_src(last);
        grant_a = (sel == SRC_A);
        grant_b = (sel == SRC_B);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_stream_mux2.sv
// Two-input round-robin stream arbiter with a one-entry registered output.
module rr_stream_mux2
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  src_t             out_src_q, out_src_d;
  src_t             last_src_q, last_src_d;

  logic             grant_a, grant_b;
  src_t             sel;
  logic [WIDTH-1:0] mux_data;
  logic             can_load;
  logic             load;

  rr_grant2 u_grant (
    .req_a   (a_valid),
    .req_b   (b_valid),
    .last    (last_src_q),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .sel     (sel)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (sel == SRC_B),
      .y   (mux_data[i])
    );
  end

  always_comb begin
    can_load = !out_valid_q || out_ready;
    // Readies are forced low while reset is asserted.
    a_ready  = rst_n && can_load && grant_a;
    b_ready  = rst_n && can_load && grant_b;
    load     = a_ready || b_ready;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_src_d  = last_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = sel;
      last_src_d  = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_A;
      last_src_q  <= RST_LAST_SRC;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_src_q  <= last_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = (out_src_q == SRC_B);

endmodule
